tlc_actuated_fsm: RTL and testbench

TLC_ACTUATED_FSM -- requirements
Module: tlc_actuated_fsm

---
 rtl/tlc_pkg.sv | 12 +
 rtl/tlc_tick_gen.sv | 16 +
 rtl/tlc_actuated_fsm.sv | 81 ++++++++
 tb/tb_tlc_actuated_fsm.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: state encoding and lamp decode shared by the traffic light controller and its bench
package tlc_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {NS_G, NS_Y, AR1, EW_G, EW_Y, AR2} state_t;
    // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    function automatic logic [5:0] lamps(input state_t s);
        return s == NS_G ? 6'b001_100 :
               s == NS_Y ? 6'b010_100 :
               s == EW_G ? 6'b100_001 :
               s == EW_Y ? 6'b100_010 : 6'b100_100;
    endfunction
endpackage

// File: rtl/tlc_tick_gen.sv
// tlc_tick_gen: prescaler counting 0..TICK_DIV-1, tick on the last count, cleared by i_clr
module tlc_tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] cnt;
    assign o_tick = cnt == W'(TICK_DIV - 1);
    always_ff @(posedge i_clk) begin
        cnt <= (i_rst || i_clr || o_tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/tlc_actuated_fsm.sv
// tlc_actuated_fsm: actuated NS/EW traffic light controller; define TLC_PED_EN for pedestrian call and walk lamp
module tlc_actuated_fsm
    import tlc_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int T_MIN_G   = 5,
    parameter int T_MAX_G   = 20,
    parameter int T_YELLOW  = 3,
    parameter int T_ALL_RED = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ew_vd,
`ifdef TLC_PED_EN
    input  logic               i_ped_req,
    output logic               o_ped_walk,
`endif
    output logic               o_ns_red,
    output logic               o_ns_yellow,
    output logic               o_ns_green,
    output logic               o_ew_red,
    output logic               o_ew_yellow,
    output logic               o_ew_green,
    output logic [STATE_W-1:0] o_state
);
    localparam int TW = $clog2(T_MAX_G + 1);
    state_t state, nxt;
    logic [TW-1:0] timer, tnext;
    logic tick, ew_req, req, min_ok;
    logic [5:0] lamp;
`ifdef TLC_PED_EN
    logic ped_req, walk;
    assign req = ew_req | ped_req;
    assign o_ped_walk = walk;
`else
    assign req = ew_req;
`endif
    assign o_state = state;
    assign {o_ns_red, o_ns_yellow, o_ns_green, o_ew_red, o_ew_yellow, o_ew_green} = lamp;
    tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (nxt != state),
        .o_tick(tick)
    );
    // decisions use the timer value after this cycle's tick so a state lasts exactly T*TICK_DIV cycles
    always_comb begin
        tnext  = (tick && timer != TW'(T_MAX_G)) ? timer + 1'b1 : timer;
        min_ok = tnext >= TW'(T_MIN_G);
        case (state)
            NS_G:    nxt = (min_ok && req) ? NS_Y : NS_G;
            NS_Y:    nxt = tnext >= TW'(T_YELLOW) ? AR1 : NS_Y;
            AR1:     nxt = tnext >= TW'(T_ALL_RED) ? EW_G : AR1;
            EW_G:    nxt = (min_ok && (!i_ew_vd || tnext == TW'(T_MAX_G))) ? EW_Y : EW_G;
            EW_Y:    nxt = tnext >= TW'(T_YELLOW) ? AR2 : EW_Y;
            AR2:     nxt = tnext >= TW'(T_ALL_RED) ? NS_G : AR2;
            default: nxt = NS_G;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= NS_G;
            timer  <= '0;
            ew_req <= 1'b0;
            lamp   <= lamps(NS_G);
`ifdef TLC_PED_EN
            ped_req <= 1'b0;
            walk    <= 1'b0;
`endif
        end else begin
            state  <= nxt;
            timer  <= (nxt != state) ? '0 : tnext;
            ew_req <= (nxt == EW_G) ? 1'b0 : ew_req | (i_ew_vd && state != EW_G);
            lamp   <= lamps(nxt);
`ifdef TLC_PED_EN
            ped_req <= (nxt == EW_G) ? 1'b0 : ped_req | (i_ped_req && state != EW_G);
            walk    <= (nxt == EW_G) && (state == EW_G ? walk : (ped_req | i_ped_req));
`endif
        end
    end
endmodule

// File: tb/tb_tlc_actuated_fsm.sv
// tb_tlc_actuated_fsm: directed self-checking bench for tlc_actuated_fsm (TICK_DIV=4, T_MIN_G=5, T_MAX_G=10)
module tb_tlc_actuated_fsm;
    import tlc_pkg::*;
    logic clk = 1'b0, rst = 1'b1, vd = 1'b0;
    logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;
    logic [STATE_W-1:0] st;
    int compared = 0, failed = 0;
    int n, bad;
`ifdef TLC_PED_EN
    logic ped = 1'b0, walk;
`endif
    always #5 clk = ~clk;
    tlc_actuated_fsm #(
        .TICK_DIV(4), .T_MIN_G(5), .T_MAX_G(10), .T_YELLOW(3), .T_ALL_RED(1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_ew_vd(vd),
`ifdef TLC_PED_EN
        .i_ped_req(ped),
        .o_ped_walk(walk),
`endif
        .o_ns_red(ns_r),
        .o_ns_yellow(ns_y),
        .o_ns_green(ns_g),
        .o_ew_red(ew_r),
        .o_ew_yellow(ew_y),
        .o_ew_green(ew_g),
        .o_state(st)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} expected for each state code
    function automatic logic [5:0] exp_lamps(input logic [STATE_W-1:0] s);
        case (s)
            3'd0:    return 6'b001100;
            3'd1:    return 6'b010100;
            3'd2:    return 6'b100100;
            3'd3:    return 6'b100001;
            3'd4:    return 6'b100010;
            3'd5:    return 6'b100100;
            default: return 6'b000000;
        endcase
    endfunction
    task automatic cyc();
        @(negedge clk);
        chk("lamp_decode", {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}, exp_lamps(st));
        chk("lamp_safety", $onehot({ns_r, ns_y, ns_g}) && $onehot({ew_r, ew_y, ew_g}) && (ns_r || ew_r), 1);
    endtask
    task automatic run_state(input string tag, input logic [STATE_W-1:0] s, input int len, input logic [STATE_W-1:0] s_next);
        int k;
        k = 0;
        while (st === s && k < 500) begin
            k++;
            cyc();
        end
        chk(tag, k, len);
        chk({tag, "_next"}, st, s_next);
    endtask
    task automatic wait_state(input string tag, input logic [STATE_W-1:0] s, input int maxc, output int k);
        k = 0;
        while (st !== s && k < maxc) begin
            k++;
            cyc();
        end
        chk(tag, st, s);
    endtask
    task automatic hold_ns_g(input string tag, input int cycles);
        int b;
        b = 0;
        repeat (cycles) begin
            cyc();
            if (st !== 3'd0) b++;
        end
        chk(tag, b, 0);
    endtask
    initial begin
        repeat (20) cyc();
        chk("reset_state", st, 0);
        chk("reset_lamps", {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}, 6'b001100);
        rst = 1'b0;
        hold_ns_g("idle_hold", 1000);
        vd = 1'b1;
        cyc();
        vd = 1'b0;
        wait_state("det_reach_ns_y", NS_Y, 10, n);
        chk("det_latency", n + 1, 2);
        run_state("ns_y_len", NS_Y, 12, AR1);
        run_state("ar1_len", AR1, 4, EW_G);
        run_state("ew_g_idle_len", EW_G, 20, EW_Y);
        run_state("ew_y_len", EW_Y, 12, AR2);
        run_state("ar2_len", AR2, 4, NS_G);
        vd = 1'b1;
        run_state("ns_g_min_len", NS_G, 20, NS_Y);
        run_state("ns_y_len2", NS_Y, 12, AR1);
        run_state("ar1_len2", AR1, 4, EW_G);
        run_state("ew_g_max_len", EW_G, 40, EW_Y);
        run_state("ew_y_len2", EW_Y, 12, AR2);
        run_state("ar2_len2", AR2, 4, NS_G);
        run_state("ns_g_served_len", NS_G, 20, NS_Y);
        run_state("ns_y_len3", NS_Y, 12, AR1);
        run_state("ar1_len3", AR1, 4, EW_G);
        vd = 1'b0;
        run_state("ew_g_drop_len", EW_G, 20, EW_Y);
        run_state("ew_y_len3", EW_Y, 12, AR2);
        run_state("ar2_len3", AR2, 4, NS_G);
        hold_ns_g("ns_g_no_req", 100);
        vd = 1'b1;
        cyc();
        vd = 1'b0;
        wait_state("reach_ew_g", EW_G, 50, n);
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_ew_g_state", st, 0);
        chk("rst_mid_ew_g_lamps", {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}, 6'b001100);
        cyc();
        chk("rst_no_yellow", st, 0);
        repeat (60) cyc();
        vd = 1'b1;
        cyc();
        vd = 1'b0;
        wait_state("reach_ns_y", NS_Y, 10, n);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_ns_y_state", st, 0);
        hold_ns_g("rst_clears_req", 60);
`ifdef TLC_PED_EN
        ped = 1'b1;
        cyc();
        ped = 1'b0;
        wait_state("ped_reach_ew_g", EW_G, 60, n);
        n = 0;
        bad = 0;
        while (st === EW_G && n < 500) begin
            n++;
            if (walk !== 1'b1) bad++;
            cyc();
        end
        chk("ped_ew_g_len", n, 20);
        chk("ped_walk_held", bad, 0);
        chk("ped_walk_off", walk, 0);
        wait_state("ped_back_ns_g", NS_G, 50, n);
        hold_ns_g("ped_req_cleared", 60);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
